// File: rtl/iter_div.sv
// ---------------------------------------------------------------------------
// iter_div : iterative restoring divider, one quotient bit per clock.
//
// Ports
//   clk, reset      single clock, asynchronous active-high reset
//   flush           abandons any operation in flight (back to IDLE next edge)
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   a, b            dividend and divisor (WIDTH bits)
//   op_signed       1 = signed, 0 = unsigned
//   op_rem          1 = return remainder, 0 = return quotient
//   op_word         1 = 32-bit word operation (only when HAS_WORD=1, WIDTH=64)
//   out_valid/out_ready result handshake; result is held while in DONE
//   result          quotient or remainder, forced to 0 whenever out_valid=0
//   busy            high in every state except IDLE
//
// Divide-by-zero and signed overflow skip the iteration and land in DONE on
// the accept edge. Every other request runs N shift-subtract steps on the
// operand magnitudes, then one FIX cycle applies signs and word extension.
// ---------------------------------------------------------------------------
module iter_div #(
   parameter int WIDTH    = 64,
   parameter int HAS_WORD = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_signed,
   input  logic             op_rem,
   input  logic             op_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ITER = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] div_q;
   logic             neg_quo;
   logic             neg_rem;
   logic             sel_rem;
   logic             word_q;
   logic [WIDTH-1:0] res_q;

   logic             word_in;
   logic [WIDTH-1:0] ext_a;
   logic [WIDTH-1:0] ext_b;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] most_neg;
   logic             div_zero;
   logic             overflow;
   logic [WIDTH-1:0] special_raw;
   logic [WIDTH-1:0] special_res;
   logic [WIDTH-1:0] dividend_init;
   logic [CW-1:0]    steps_init;

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] quo_fixed;
   logic [WIDTH-1:0] rem_fixed;
   logic [WIDTH-1:0] fix_res;

   // Copies bit 31 into every bit above it when en is set; a no-op for WIDTH=32.
   function automatic logic [WIDTH-1:0] sext31(input logic [WIDTH-1:0] v, input logic en);
      logic [WIDTH-1:0] r;
      r = v;
      if (en) begin
         for (int i = 32; i < WIDTH; i++) begin
            r[i] = v[31];
         end
      end
      return r;
   endfunction

   // Accept-side decode: effective operands, magnitudes and the two special cases.
   // In word mode the dividend magnitude is left-aligned so the iteration always
   // consumes bits from the top of quo_q, whatever N is.
   always_comb begin
      word_in = (HAS_WORD != 0) && (WIDTH == 64) && op_word;
      ext_a   = a;
      ext_b   = b;
      if (word_in) begin
         for (int i = 32; i < WIDTH; i++) begin
            ext_a[i] = op_signed & a[31];
            ext_b[i] = op_signed & b[31];
         end
      end
      a_neg    = op_signed & ext_a[WIDTH-1];
      b_neg    = op_signed & ext_b[WIDTH-1];
      abs_a    = a_neg ? (~ext_a + 1'b1) : ext_a;
      abs_b    = b_neg ? (~ext_b + 1'b1) : ext_b;
      most_neg = word_in ? ({WIDTH{1'b1}} << 31) : ({WIDTH{1'b1}} << (WIDTH - 1));
      div_zero = (ext_b == '0);
      overflow = op_signed && (ext_a == most_neg) && (ext_b == '1);
      if (div_zero) begin
         special_raw = op_rem ? ext_a : '1;
      end else begin
         special_raw = op_rem ? '0 : ext_a;
      end
      special_res   = sext31(special_raw, word_in);
      dividend_init = word_in ? (abs_a << (WIDTH - 32)) : abs_a;
      steps_init    = word_in ? CW'(32) : CW'(WIDTH);
   end

   // One restoring step: shift the next dividend bit into the partial remainder
   // and keep the subtraction only when it does not go negative.
   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      diff      = rem_shift - {1'b0, div_q};
      fits      = ~diff[WIDTH];
   end

   // Sign correction and result selection used by the FIX cycle.
   always_comb begin
      quo_fixed = neg_quo ? (~quo_q + 1'b1) : quo_q;
      rem_fixed = neg_rem ? (~rem_q + 1'b1) : rem_q;
      fix_res   = sext31(sel_rem ? rem_fixed : quo_fixed, word_q);
   end

   // Control FSM and datapath registers; flush beats every other request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
         sel_rem <= 1'b0;
         word_q  <= 1'b0;
         res_q   <= '0;
      end else if (flush) begin
         state <= IDLE;
         count <= '0;
         res_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sel_rem <= op_rem;
                  word_q  <= word_in;
                  if (div_zero || overflow) begin
                     res_q <= special_res;
                     state <= DONE;
                  end else begin
                     rem_q   <= '0;
                     quo_q   <= dividend_init;
                     div_q   <= abs_b;
                     neg_quo <= a_neg ^ b_neg;
                     neg_rem <= a_neg;
                     count   <= steps_init;
                     state   <= ITER;
                  end
               end
            end
            ITER: begin
               rem_q <= fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], fits};
               count <= count - 1'b1;
               if (count == CW'(1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               res_q <= fix_res;
               state <= DONE;
            end
            default: begin
               if (out_ready) begin
                  res_q <= '0;
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign result    = out_valid ? res_q : '0;

endmodule

// File: tb/tb_iter_div.sv
// ---------------------------------------------------------------------------
// tb_iter_div : directed self-checking bench for iter_div (WIDTH=64, word on).
// A table of operations with hand-computed results and latencies, followed by
// hand-written backpressure, flush and reset-abandon sequences.
// ---------------------------------------------------------------------------
module tb_iter_div;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        op_signed;
   logic        op_rem;
   logic        op_word;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [63:0] a;
      logic [63:0] b;
      logic        s;
      logic        r;
      logic        w;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[18];

   iter_div #(.WIDTH(64), .HAS_WORD(1)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op_signed(op_signed), .op_rem(op_rem), .op_word(op_word),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Last-resort guard so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, act, exp);
      end
   endtask

   // Waits for IDLE, presents one request, scrambles the inputs after the accept
   // edge, then counts cycles until out_valid (latency 1 = visible right after accept).
   task automatic applyStimulus(input logic [63:0] va, input logic [63:0] vb,
                                input logic vs, input logic vr, input logic vw,
                                output logic [63:0] res, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      a         = va;
      b         = vb;
      op_signed = vs;
      op_rem    = vr;
      op_word   = vw;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      a         = {$urandom, $urandom};
      b         = {$urandom, $urandom};
      op_signed = ~vs;
      op_rem    = ~vr;
      op_word   = ~vw;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = result;
   endtask

   task automatic abandonScenario(input string name, input logic use_reset);
      logic [63:0] res;
      int          lat;
      logic        seen;
      while (!in_ready) begin
         @(posedge clk);
         #1;
      end
      a = 64'd100; b = 64'd7; op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checkOutput({name, "_busy_iter"}, {63'd0, busy}, 64'd1);
      checkOutput({name, "_res0_iter"}, result, 64'd0);
      if (use_reset) begin
         #2;
         reset = 1'b1;
         #1;
         checkOutput({name, "_async_ready"}, {63'd0, in_ready}, 64'd1);
         checkOutput({name, "_async_busy"}, {63'd0, busy}, 64'd0);
         @(posedge clk);
         #1;
         reset = 1'b0;
      end else begin
         flush = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
         checkOutput({name, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
         checkOutput({name, "_idle_busy"}, {63'd0, busy}, 64'd0);
      end
      seen = 1'b0;
      repeat (70) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      checkOutput({name, "_no_valid"}, {63'd0, seen}, 64'd0);
      applyStimulus(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, res, lat);
      checkOutput({name, "_after_res"}, res, 64'd3);
      checkOutput({name, "_after_lat"}, 64'(lat), 64'd66);
   endtask

   // Main test sequence.
   initial begin
      logic [63:0] res;
      int          lat;

      vecs[0]  = '{"sdiv_m7_2_q",  64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFD, 66};
      vecs[1]  = '{"sdiv_m7_2_r",  64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 66};
      vecs[2]  = '{"divz_q",       64'd100, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1};
      vecs[3]  = '{"divz_r",       64'd100, 64'd0, 1'b0, 1'b1, 1'b0, 64'd100, 1};
      vecs[4]  = '{"ovf_q",        64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0, 64'h8000000000000000, 1};
      vecs[5]  = '{"ovf_r",        64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0, 64'd0, 1};
      vecs[6]  = '{"word_u_q",     64'h00000000FFFFFFFE, 64'd1, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFE, 34};
      vecs[7]  = '{"udiv_100_7_q", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 66};
      vecs[8]  = '{"udiv_100_7_r", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd2, 66};
      vecs[9]  = '{"sdiv_7_m2_r",  64'd7, 64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b1, 1'b0, 64'd1, 66};
      vecs[10] = '{"sdiv_m9_m3_q", 64'hFFFFFFFFFFFFFFF7, 64'hFFFFFFFFFFFFFFFD, 1'b1, 1'b0, 1'b0, 64'd3, 66};
      vecs[11] = '{"word_s_q",     64'h12345678FFFFFFF9, 64'hABCDEF0000000002, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFD, 34};
      vecs[12] = '{"word_s_r",     64'h12345678FFFFFFF9, 64'hABCDEF0000000002, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 34};
      vecs[13] = '{"word_ovf_q",   64'h0000000080000000, 64'h00000000FFFFFFFF, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFF80000000, 1};
      vecs[14] = '{"word_divz_r",  64'h0000000080000005, 64'h0000000100000000, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFF80000005, 1};
      vecs[15] = '{"umax_1_q",     64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 66};
      vecs[16] = '{"umax_16_q",    64'hFFFFFFFFFFFFFFFF, 64'h10, 1'b0, 1'b0, 1'b0, 64'h0FFFFFFFFFFFFFFF, 66};
      vecs[17] = '{"umax_16_r",    64'hFFFFFFFFFFFFFFFF, 64'h10, 1'b0, 1'b1, 1'b0, 64'hF, 66};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;

      // Reset state, observed before the first clock edge.
      #2;
      checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_result", result, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].w, res, lat);
         checkOutput({vecs[i].name, "_res"}, res, vecs[i].exp);
         checkOutput({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      end

      // Backpressure: hold a divide-by-zero result for five cycles.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      applyStimulus(64'd100, 64'd0, 1'b0, 1'b0, 1'b0, res, lat);
      checkOutput("bp_lat", 64'(lat), 64'd1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
         checkOutput("bp_result", result, 64'hFFFFFFFFFFFFFFFF);
         checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_retire_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("bp_retire_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("bp_retire_result", result, 64'd0);
      a = 64'd9; b = 64'd3; op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("bp_next_accepted", {63'd0, busy}, 64'd1);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("bp_next_res", result, 64'd3);
      checkOutput("bp_next_lat", 64'(lat), 64'd66);

      abandonScenario("flush", 1'b0);
      abandonScenario("reset", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits; legal values 32 and 64.
REQ-002 Parameter HAS_WORD, default 1: enables 32-bit word mode; legal only with WIDTH=64. When 0, op_word is ignored.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  abandons any operation in flight.
REQ-006 in_valid  input  1  a request is presented.
REQ-007 in_ready  output  1  the unit can accept a request.
REQ-008 a  input  WIDTH  dividend.
REQ-009 b  input  WIDTH  divisor.
REQ-010 op_signed  input  1  1 = signed operation, 0 = unsigned.
REQ-011 op_rem  input  1  1 = return remainder, 0 = return quotient.
REQ-012 op_word  input  1  1 = 32-bit word operation; result is sign-extended to WIDTH.
REQ-013 out_valid  output  1  result is valid.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 result  output  WIDTH  quotient or remainder.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL implement a four-state FSM: IDLE, ITER, FIX, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where state=IDLE, in_valid=1 and flush=0.
REQ-019 On accept, all of a, b, op_signed, op_rem and op_word SHALL be captured; later input changes SHALL have no effect on the operation in flight.
REQ-020 Effective width N SHALL be 32 when op_word=1 and HAS_WORD=1, otherwise WIDTH.
REQ-021 In word mode, operands SHALL be the low 32 bits of a and b, sign-extended when op_signed=1 and zero-extended otherwise.
REQ-022 Divide-by-zero case (effective b=0): the accept edge SHALL go directly to DONE.
  - Quotient: all ones.
  - Remainder: the effective dividend.
REQ-023 Signed-overflow case (op_signed=1, effective a = most negative N-bit value, effective b = -1): the accept edge SHALL go directly to DONE.
  - Quotient: effective a.
  - Remainder: 0.
REQ-024 Otherwise, the accept edge SHALL:
  - latch the absolute values of the operands (raw values if unsigned);
  - latch the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a));
  - load the iteration counter with N;
  - enter ITER.
REQ-025 ITER SHALL perform one restoring shift-subtract step per cycle, decrementing the counter; after N steps the FSM SHALL enter FIX.
REQ-026 FIX SHALL, in one cycle:
  - negate the quotient and/or remainder according to the latched signs;
  - select the quotient or remainder per op_rem;
  - in word mode, sign-extend bit 31 to WIDTH;
  - enter DONE.
REQ-027 Special-case results (REQ-022/023) SHALL also be sign-extended from bit 31 in word mode.
REQ-028 In DONE, out_valid SHALL be 1 and result SHALL be held stable; on an edge with out_ready=1 the FSM SHALL return to IDLE.
REQ-029 Latency from accept edge to out_valid=1:
  - normal case: N+2 cycles (66 for WIDTH=64, 34 for word mode);
  - special cases: 1 cycle.
REQ-030 Back-to-back requests: the next request is accepted no earlier than the cycle after the edge that retires DONE.
REQ-031 flush=1 SHALL force IDLE on the next edge from any state, including DONE.
  - No out_valid is produced for the flushed operation.
  - flush takes priority over in_valid and out_ready in the same cycle.
REQ-032 out_valid SHALL be 0 in IDLE, ITER and FIX.
REQ-033 result SHALL be 0 whenever out_valid=0.

Reset
REQ-034 While reset is asserted, the block SHALL be in IDLE, independent of clk, with:
  - in_ready=1;
  - out_valid=0, busy=0, result=0;
  - counter and internal datapath registers cleared.
REQ-035 Reset asserted mid-operation SHALL discard the operation; no out_valid follows deassertion.

Verification
REQ-036 Signed divide, WIDTH=64: a=-7, b=2, op_signed=1, op_rem=0 -> result=0xFFFFFFFFFFFFFFFD 66 cycles after accept. Repeat with op_rem=1 -> 0xFFFFFFFFFFFFFFFF.
REQ-037 Divide by zero, unsigned: a=100, b=0.
  - op_rem=0 -> result=0xFFFFFFFFFFFFFFFF one cycle after accept.
  - op_rem=1 -> result=100.
REQ-038 Overflow: a=0x8000000000000000, b=-1, op_signed=1.
  - op_rem=0 -> result=0x8000000000000000 after 1 cycle.
  - op_rem=1 -> result=0.
REQ-039 Word unsigned: a=0x00000000FFFFFFFE, b=1, op_word=1, op_signed=0 -> result=0xFFFFFFFFFFFFFFFE after 34 cycles.
REQ-040 Backpressure: out_ready held 0 for 5 cycles in DONE -> result and out_valid stable and in_ready=0 throughout; out_ready=1 -> IDLE, next request accepted the following cycle.
REQ-041 Flush and reset abandon: flush at ITER cycle 10 -> IDLE next cycle, no out_valid; a new request of 9/3 completes with result 3. Repeat the scenario with reset instead of flush.
